// File: rtl/vram_write_queue_pkg.sv
// Shared constants and entry type for the VRAM write path.
package vram_pkg;
   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int MAX_WR_RUN = 7;
   // Phase of the 16-cycle video schedule that carries the write/refresh slot
   localparam int SLOT_PHASE = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;
endpackage

// File: rtl/vram_write_queue_if.sv
// Decoder-side request bus and SDRAM-side slot bus of the write queue.
interface vram_write_queue_if #(
   parameter int ADDR_W     = vram_pkg::ADDR_W,
   parameter int DATA_W     = vram_pkg::DATA_W,
   parameter int DEPTH_LOG2 = vram_pkg::DEPTH_LOG2
);
   logic                  in_valid;
   logic [ADDR_W-1:0]     in_addr;
   logic [DATA_W-1:0]     in_data;
   logic                  in_ready;
   logic                  slot;
   logic                  init_busy;
   logic                  sd_wr;
   logic                  sd_rfsh;
   logic [ADDR_W-1:0]     sd_addr;
   logic [DATA_W-1:0]     sd_wdata;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  overflow_clr;

   // Queue side
   modport slave (
      input  in_valid, in_addr, in_data, slot, init_busy, overflow_clr,
      output in_ready, sd_wr, sd_rfsh, sd_addr, sd_wdata, level, overflow
   );

   // Decoder / scheduler side
   modport master (
      output in_valid, in_addr, in_data, slot, init_busy, overflow_clr,
      input  in_ready, sd_wr, sd_rfsh, sd_addr, sd_wdata, level, overflow
   );
endinterface

// File: rtl/vram_write_queue_sync_fifo.sv
// Generic synchronous FIFO with a registered head word and entry count.
module sync_fifo #(
   parameter int WIDTH      = 24,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      din_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      dout_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [WIDTH-1:0]      head_q;
   logic                  do_push, do_pop;

   // Level never exceeds DEPTH, so its MSB alone flags full
   assign full_o  = level_q[DEPTH_LOG2];
   assign empty_o = (level_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rd_nxt  = rd_ptr_q + 1'b1;
   assign level_o = level_q;
   assign dout_o  = head_q;

   // Next level: simultaneous push and pop leave it unchanged
   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers and level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_nxt;
         level_q <= level_d;
      end
   end

   // Head register: next stored entry on pop, or bypass the incoming word
   // when it becomes the only entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
      end else if (do_pop) begin
         if (level_q > LVL_ONE) head_q <= mem_q[rd_nxt];
         else if (do_push)      head_q <= din_i;
      end else if (do_push && empty_o) begin
         head_q <= din_i;
      end
   end
endmodule

// File: rtl/vram_write_queue.sv
// Byte-write queue feeding the SDRAM write/refresh slot, with refresh starvation guard.
module vram_write_queue
   import vram_pkg::*;
#(
   parameter int DEPTH_LOG2 = vram_pkg::DEPTH_LOG2,
   parameter int MAX_WR_RUN = vram_pkg::MAX_WR_RUN
) (
   input  logic               clk,
   input  logic               reset_n,
   vram_write_queue_if.slave  bus
);
   localparam int RUN_W = $clog2(MAX_WR_RUN + 1);

   wr_entry_t         in_ent, head;
   logic              full, empty, push, force_rfsh, wr, rfsh;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              ovf_q, ovf_d;

   assign in_ent.addr = bus.in_addr;
   assign in_ent.data = bus.in_data;
   assign push        = bus.in_valid & ~full;

   // Slot decision; reset_n gating keeps both strobes quiet while held in reset
   assign force_rfsh  = (run_q == RUN_W'(MAX_WR_RUN));
   assign wr          = reset_n & bus.slot & ~empty & ~bus.init_busy & ~force_rfsh;
   assign rfsh        = reset_n & bus.slot & ~wr;

   sync_fifo #(
      .WIDTH      ($bits(wr_entry_t)),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .din_i   (in_ent),
      .pop_i   (wr),
      .dout_o  (head),
      .level_o (bus.level),
      .full_o  (full),
      .empty_o (empty)
   );

   assign bus.in_ready = ~full;
   assign bus.sd_wr    = wr;
   assign bus.sd_rfsh  = rfsh;
   assign bus.sd_addr  = head.addr;
   assign bus.sd_wdata = head.data;
   assign bus.overflow = ovf_q;

   // Run length of consecutive write slots and sticky overflow next-state
   always_comb begin
      run_d = run_q;
      if (wr)        run_d = run_q + 1'b1;
      else if (rfsh) run_d = '0;
      ovf_d = ovf_q;
      if (bus.overflow_clr)              ovf_d = 1'b0;
      else if (bus.in_valid && full)     ovf_d = 1'b1;
   end

   // Run counter and overflow flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         run_q <= run_d;
         ovf_q <= ovf_d;
      end
   end
endmodule

// File: tb/tb_vram_write_queue.sv
module tb_vram_write_queue;
   import vram_pkg::*;

   typedef struct {
      logic        wr;
      logic [15:0] a;
      logic [7:0]  d;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   vram_write_queue_if bus ();

   vram_write_queue dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; a slot queues its expected outcome and is followed
   // by idle cycles until the next schedule slot
   task automatic drive(input logic v, input logic [15:0] a, input logic [7:0] d,
                        input logic s, input logic ewr, input logic [15:0] ea, input logic [7:0] ed);
      exp_t e;
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
      bus.slot     = s;
      if (s) begin
         e.wr = ewr; e.a = ea; e.d = ed;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.slot     = 1'b0;
      if (s) begin
         repeat (SLOT_PHASE - 1) @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d);
      drive(1'b1, a, d, 1'b0, 1'b0, 16'h0, 8'h0);
   endtask

   task automatic slot_wr(input logic [15:0] ea, input logic [7:0] ed);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b1, ea, ed);
   endtask

   task automatic slot_rf();
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0, 8'h0);
   endtask

   // Monitor: every slot must match the next queued expectation
   always @(negedge clk) begin
      if (reset_n && bus.slot) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL slot_unexpected: wr=%0b rfsh=%0b with nothing expected", bus.sd_wr, bus.sd_rfsh);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.sd_wr !== mon_e.wr || bus.sd_rfsh !== !mon_e.wr ||
                (mon_e.wr && (bus.sd_addr !== mon_e.a || bus.sd_wdata !== mon_e.d))) begin
               n_err++;
               $display("FAIL slot: got wr=%0b rfsh=%0b addr=%h data=%h expected wr=%0b rfsh=%0b addr=%h data=%h",
                        bus.sd_wr, bus.sd_rfsh, bus.sd_addr, bus.sd_wdata,
                        mon_e.wr, !mon_e.wr, mon_e.a, mon_e.d);
            end
         end
      end else if (reset_n) begin
         n_cmp++;
         if (bus.sd_wr !== 1'b0 || bus.sd_rfsh !== 1'b0) begin
            n_err++;
            $display("FAIL strobe_outside_slot: wr=%0b rfsh=%0b expected 0 0", bus.sd_wr, bus.sd_rfsh);
         end
      end
   end

   initial begin
      int idx;
      bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
      bus.slot = 1'b0; bus.init_busy = 1'b0; bus.overflow_clr = 1'b0;

      // Reset state
      #12;
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_sd_addr", 32'(bus.sd_addr), 0);
      chk("rst_strobes", {30'd0, bus.sd_wr, bus.sd_rfsh}, 0);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // Three writes in order, then a refresh on the empty queue
      push(16'h0100, 8'h11); push(16'h0101, 8'h22); push(16'h0102, 8'h33);
      chk("t1_level3", 32'(bus.level), 3);
      slot_wr(16'h0100, 8'h11); slot_wr(16'h0101, 8'h22); slot_wr(16'h0102, 8'h33);
      slot_rf();
      chk("t1_level0", 32'(bus.level), 0);

      // Fill past capacity: 17th dropped, overflow set; clear beats same-cycle set
      for (int i = 0; i < 17; i++) push(16'h0200 + 16'(i), 8'h40 + 8'(i));
      chk("t2_level16", 32'(bus.level), 16);
      chk("t2_in_ready", 32'(bus.in_ready), 0);
      chk("t2_overflow", 32'(bus.overflow), 1);
      bus.overflow_clr = 1'b1;
      push(16'h02FF, 8'hEE);
      bus.overflow_clr = 1'b0;
      chk("t2_clr_priority", 32'(bus.overflow), 0);
      push(16'h02FE, 8'hED);
      chk("t2_overflow_again", 32'(bus.overflow), 1);
      chk("t2_level_still16", 32'(bus.level), 16);
      // Drain: refresh forced after every 7 writes, entries in arrival order
      idx = 0;
      for (int k = 0; k < 19; k++) begin
         if (k % 8 == 7 || idx >= 16) slot_rf();
         else begin
            slot_wr(16'h0200 + 16'(idx), 8'h40 + 8'(idx));
            idx++;
         end
         if (k == 0) chk("t2_in_ready_after_pop", 32'(bus.in_ready), 1);
      end
      chk("t2_drained", 32'(bus.level), 0);
      chk("t2_overflow_sticky", 32'(bus.overflow), 1);
      bus.overflow_clr = 1'b1;
      @(posedge clk); #1;
      bus.overflow_clr = 1'b0;
      chk("t2_overflow_cleared", 32'(bus.overflow), 0);

      // Sustained traffic with push+pop each slot: 7 writes then 1 refresh
      push(16'h0300, 8'hC0); push(16'h0301, 8'hC1);
      idx = 0;
      for (int k = 0; k < 16; k++) begin
         if (k % 8 == 7)
            drive(1'b1, 16'h0302 + 16'(k), 8'hC2 + 8'(k), 1'b1, 1'b0, 16'h0, 8'h0);
         else begin
            drive(1'b1, 16'h0302 + 16'(k), 8'hC2 + 8'(k), 1'b1, 1'b1, 16'h0300 + 16'(idx), 8'hC0 + 8'(idx));
            idx++;
         end
         if (k == 0) chk("t3_pushpop_level", 32'(bus.level), 2);
      end
      chk("t3_level4", 32'(bus.level), 4);

      // Controller initialising: slots become refresh, queue held
      bus.init_busy = 1'b1;
      slot_rf(); slot_rf(); slot_rf();
      chk("t4_busy_level", 32'(bus.level), 4);
      bus.init_busy = 1'b0;
      slot_wr(16'h030E, 8'hCE); slot_wr(16'h030F, 8'hCF);
      slot_wr(16'h0310, 8'hD0); slot_wr(16'h0311, 8'hD1);
      chk("t4_level0", 32'(bus.level), 0);

      // Push into empty queue in the same cycle as a slot: not visible yet
      drive(1'b1, 16'h0500, 8'h50, 1'b1, 1'b0, 16'h0, 8'h0);
      slot_wr(16'h0500, 8'h50);
      for (int i = 0; i < 5; i++) push(16'h0510 + 16'(i), 8'h60 + 8'(i));
      drive(1'b1, 16'h0515, 8'h65, 1'b1, 1'b1, 16'h0510, 8'h60);
      chk("t5_pushpop_level5", 32'(bus.level), 5);
      push(16'h0516, 8'h66);
      slot_wr(16'h0511, 8'h61);
      push(16'h0517, 8'h67);
      chk("t5_level6", 32'(bus.level), 6);

      // Asynchronous reset mid-operation, with a slot asserted
      reset_n = 1'b0;
      bus.slot = 1'b1;
      #2;
      chk("t6_level", 32'(bus.level), 0);
      chk("t6_in_ready", 32'(bus.in_ready), 1);
      chk("t6_strobes", {30'd0, bus.sd_wr, bus.sd_rfsh}, 0);
      chk("t6_head", {8'd0, bus.sd_addr, bus.sd_wdata}, 0);
      bus.slot = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;
      push(16'h0A00, 8'hA5);
      slot_wr(16'h0A00, 8'hA5);
      slot_rf();
      chk("t6_level0", 32'(bus.level), 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
